// File: rtl/bram_fifo_ctrl.sv
// Single-clock FIFO controller driving one dual-port bram as storage, with a
// registered output-valid stage. Define BRAM_FIFO_CTRL_LEVEL_EN to add o_level.
module bram_fifo_ctrl #(
    parameter int unsigned DATA_SZ = 16,
    parameter int unsigned ADDR_SZ = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DATA_SZ-1:0] i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_SZ-1:0] o_data,
    output logic               o_wr_en,
    output logic [ADDR_SZ-1:0] o_waddr,
    output logic [DATA_SZ-1:0] o_wdata,
    output logic               o_rd_en,
    output logic [ADDR_SZ-1:0] o_raddr,
    input  logic [DATA_SZ-1:0] i_rdata,
    output logic               o_full,
    output logic               o_empty
`ifdef BRAM_FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_SZ:0]   o_level
`endif
);

    localparam int unsigned PTR_SZ = ADDR_SZ + 1;

    logic [PTR_SZ-1:0] r_wp;
    logic [PTR_SZ-1:0] r_rp;
    logic              r_valid;

    logic w_empty;
    logic w_full;
    logic w_wr;
    logic w_rd;

    // Extra pointer MSB distinguishes a full ring from an empty one.
    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[ADDR_SZ] != r_rp[ADDR_SZ]) &&
                     (r_wp[ADDR_SZ-1:0] == r_rp[ADDR_SZ-1:0]);

    assign w_wr = i_valid & ~w_full;
    assign w_rd = ~w_empty & (~r_valid | i_ready);

    assign o_ready = ~w_full;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_wr_en = w_wr;
    assign o_waddr = r_wp[ADDR_SZ-1:0];
    assign o_wdata = i_data;
    assign o_rd_en = w_rd;
    assign o_raddr = r_rp[ADDR_SZ-1:0];
    assign o_data  = i_rdata;
    assign o_valid = r_valid;

    // Pointers and the output stage; bram holds rdata whenever no read is issued.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + PTR_SZ'(1);
            end
            if (w_rd) begin
                r_rp <= r_rp + PTR_SZ'(1);
            end
            r_valid <= w_rd | (r_valid & ~i_ready);
        end
    end

`ifdef BRAM_FIFO_CTRL_LEVEL_EN
    logic [PTR_SZ-1:0] r_level;

    // Moving a word into the output stage leaves the level unchanged; only consumption lowers it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= '0;
        end else begin
            r_level <= r_level + PTR_SZ'(w_wr) - PTR_SZ'(r_valid & i_ready);
        end
    end

    assign o_level = r_level;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed self-checking bench for bram_fifo_ctrl with a behavioural bram model.
module tb_bram_fifo_ctrl;

    localparam int unsigned DATA_SZ = 16;
    localparam int unsigned ADDR_SZ = 8;

    logic               clk;
    logic               rst_n;
    logic               i_valid;
    logic               o_ready;
    logic [DATA_SZ-1:0] i_data;
    logic               o_valid;
    logic               i_ready;
    logic [DATA_SZ-1:0] o_data;
    logic               o_wr_en;
    logic [ADDR_SZ-1:0] o_waddr;
    logic [DATA_SZ-1:0] o_wdata;
    logic               o_rd_en;
    logic [ADDR_SZ-1:0] o_raddr;
    logic [DATA_SZ-1:0] bram_rdata;
    logic               o_full;
    logic               o_empty;
`ifdef BRAM_FIFO_CTRL_LEVEL_EN
    logic [ADDR_SZ:0]   o_level;
`endif

    int n_total = 0;
    int n_bad   = 0;

    bram_fifo_ctrl #(.DATA_SZ(DATA_SZ), .ADDR_SZ(ADDR_SZ)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_wr_en (o_wr_en),
        .o_waddr (o_waddr),
        .o_wdata (o_wdata),
        .o_rd_en (o_rd_en),
        .o_raddr (o_raddr),
        .i_rdata (bram_rdata),
        .o_full  (o_full),
        .o_empty (o_empty)
`ifdef BRAM_FIFO_CTRL_LEVEL_EN
        ,
        .o_level (o_level)
`endif
    );

    // bram model: registered read that holds its output when no read is issued
    logic [DATA_SZ-1:0] mem [1 << ADDR_SZ];
    always @(posedge clk) begin
        if (o_wr_en) mem[o_waddr] <= o_wdata;
        if (o_rd_en) bram_rdata <= mem[o_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle_io(input logic v, input logic [DATA_SZ-1:0] d, input logic r);
        @(negedge clk);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        #1;
    endtask

    // Consume cnt words expecting first, first+1, ...; then confirm the FIFO is idle.
    task automatic drain(input string tag, input int first, input int cnt);
        int got = 0;
        for (int c = 0; c < cnt + 20 && got < cnt; c++) begin
            cycle_io(1'b0, '0, 1'b1);
            if (o_valid) begin
                check_eq(tag, 32'(o_data), 32'(16'(first + got)));
                got++;
            end
        end
        check_eq({tag, "_cnt"}, 32'(got), 32'(cnt));
        cycle_io(1'b0, '0, 1'b1);
        check_eq({tag, "_vld0"}, 32'(o_valid), 32'd0);
        check_eq({tag, "_empty"}, 32'(o_empty), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        #1;
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_empty", 32'(o_empty), 32'd1);
        check_eq("rst_ready", 32'(o_ready), 32'd1);
        check_eq("rst_full", 32'(o_full), 32'd0);
        check_eq("rst_rd_en", 32'(o_rd_en), 32'd0);
        check_eq("rst_wr_en", 32'(o_wr_en), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_d;
        int ew;
        int er;
        logic hold;
        logic [DATA_SZ-1:0] prev;

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        do_reset();

        // single word latency
        cycle_io(1'b1, 16'hA5A5, 1'b1);
        check_eq("sw_wr_en", 32'(o_wr_en), 32'd1);
        check_eq("sw_waddr", 32'(o_waddr), 32'd0);
        check_eq("sw_rd_en0", 32'(o_rd_en), 32'd0);
        cycle_io(1'b0, '0, 1'b1);
        check_eq("sw_rd_en", 32'(o_rd_en), 32'd1);
        check_eq("sw_raddr", 32'(o_raddr), 32'd0);
        check_eq("sw_vld_early", 32'(o_valid), 32'd0);
        cycle_io(1'b0, '0, 1'b1);
        check_eq("sw_valid", 32'(o_valid), 32'd1);
        check_eq("sw_data", 32'(o_data), 32'h0000A5A5);
        cycle_io(1'b0, '0, 1'b1);
        check_eq("sw_valid_off", 32'(o_valid), 32'd0);
        check_eq("sw_empty", 32'(o_empty), 32'd1);

        // fill: one word moves to the output stage, then 256 fill storage
        for (int k = 0; k < 257; k++) begin
            cycle_io(1'b1, 16'(k), 1'b0);
            check_eq("fill_wr_en", 32'(o_wr_en), 32'd1);
        end
        cycle_io(1'b1, 16'hDEAD, 1'b0);
        check_eq("fill_full", 32'(o_full), 32'd1);
        check_eq("fill_ready", 32'(o_ready), 32'd0);
        check_eq("fill_drop", 32'(o_wr_en), 32'd0);
        check_eq("fill_head", 32'(o_data), 32'd0);
        drain("fill_drain", 0, 257);

        // backpressure with i_ready toggling every cycle
        exp_d = 1;
        hold  = 1'b0;
        prev  = '0;
        for (int c = 0; c < 40; c++) begin
            cycle_io(c < 8, 16'(c + 1), c[0]);
            if (o_valid) begin
                if (hold) check_eq("bp_stable", 32'(o_data), 32'(prev));
                if (i_ready) begin
                    check_eq("bp_data", 32'(o_data), 32'(exp_d));
                    exp_d++;
                end
            end
            hold = o_valid & ~i_ready;
            prev = o_data;
        end
        check_eq("bp_cnt", 32'(exp_d - 1), 32'd8);
        check_eq("bp_empty", 32'(o_empty), 32'd1);

        // simultaneous read and write with 3 words in storage
        for (int k = 0; k < 4; k++) cycle_io(1'b1, 16'(10 + k), 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle_io(1'b1, 16'(14 + k), 1'b1);
            check_eq("rw_wr", 32'(o_wr_en), 32'd1);
            check_eq("rw_rd", 32'(o_rd_en), 32'd1);
            check_eq("rw_count", 32'(8'(o_waddr - o_raddr)), 32'd3);
            check_eq("rw_data", 32'(o_data), 32'(10 + k));
        end
        drain("rw_drain", 16, 4);

        // reset mid-stream discards stored words
        for (int k = 0; k < 3; k++) cycle_io(1'b1, 16'(16'h77 + k), 1'b0);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle_io(1'b0, '0, 1'b1);
            check_eq("post_rst_vld", 32'(o_valid), 32'd0);
        end

        // wrap: 600 words at full rate
        exp_d = 0;
        ew    = 0;
        er    = 0;
        for (int c = 0; c < 610; c++) begin
            cycle_io(c < 600, 16'(16'h1000 + c), 1'b1);
            if (c < 600) check_eq("wrap_wr", 32'(o_wr_en), 32'd1);
            if (o_wr_en) begin
                check_eq("wrap_waddr", 32'(o_waddr), 32'(ew % 256));
                ew++;
            end
            if (o_rd_en) begin
                check_eq("wrap_raddr", 32'(o_raddr), 32'(er % 256));
                er++;
            end
            if (o_valid) begin
                check_eq("wrap_data", 32'(o_data), 32'(16'h1000 + exp_d));
                exp_d++;
            end
        end
        check_eq("wrap_cnt", 32'(exp_d), 32'd600);
        check_eq("wrap_empty", 32'(o_empty), 32'd1);

`ifdef BRAM_FIFO_CTRL_LEVEL_EN
        do_reset();
        cycle_io(1'b0, '0, 1'b0);
        check_eq("lvl_rst", 32'(o_level), 32'd0);
        for (int k = 0; k < 5; k++) cycle_io(1'b1, 16'(16'h50 + k), 1'b0);
        cycle_io(1'b0, '0, 1'b0);
        check_eq("lvl_5", 32'(o_level), 32'd5);
        cycle_io(1'b0, '0, 1'b1);
        check_eq("lvl_head", 32'(o_data), 32'h50);
        cycle_io(1'b0, '0, 1'b0);
        check_eq("lvl_4", 32'(o_level), 32'd4);
        drain("lvl_drain", 16'h51, 4);
        check_eq("lvl_0", 32'(o_level), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
